debounce_scan_ctrl: RTL

Multi-channel debounce controller. One shared sample-tick prescaler and one scan FSM serve N noisy inputs, so each channel does not need its own wide stability counter. Each channel is sampled once per tick in round-robin order. The block drives a clean level vector and pushes edge events into a small FIFO with a valid/ready handshake. It sits between the board buttons/switches and the control logic that consumes press/release events.

---
 rtl/debounce_scan_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/debounce_scan_ctrl.sv
// Multi-channel debouncer: shared tick prescaler, round-robin scan FSM, edge-event FIFO.
// Optional long-press events are built when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_scan_ctrl #(
   parameter int unsigned N_CH         = 4,
   parameter int unsigned TICK_DIV     = 1000,
   parameter int unsigned STABLE_TICKS = 8,
   parameter int unsigned EVT_DEPTH    = 4,
   parameter int unsigned LONG_TICKS   = 500
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    en_in,
   input  logic [N_CH-1:0]         noisy_in,
   output logic [N_CH-1:0]         clean_out,
   output logic                    busy_out,
   output logic                    evt_valid_out,
   input  logic                    evt_ready_in,
   output logic [$clog2(N_CH)-1:0] evt_ch_out,
   output logic                    evt_rise_out,
   output logic                    evt_long_out,
   output logic                    ovf_out,
   input  logic                    ovf_clr_in
);

   localparam int unsigned CH_W = $clog2(N_CH);
   localparam int unsigned PW   = $clog2(TICK_DIV);
   localparam int unsigned AW   = $clog2(EVT_DEPTH);
   localparam int unsigned CW   = AW + 1;

   if (TICK_DIV <= N_CH + 1 || STABLE_TICKS < 2 || STABLE_TICKS > 255 ||
       LONG_TICKS < 1 || LONG_TICKS > 65535) begin : g_cfg_err
      $error("debounce_scan_ctrl: illegal parameter set");
   end

   typedef enum logic {S_IDLE, S_SCAN} state_t;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic            rise;
      logic            long_evt;
   } evt_t;

   logic [N_CH-1:0] sync1_q, sync2_q;
   logic [PW-1:0]   presc_q, presc_d;
   logic            tick;
   state_t          state_q, state_d;
   logic [CH_W-1:0] ch_idx_q, ch_idx_d;
   logic            busy_q, busy_d;
   logic [N_CH-1:0] clean_q, clean_d;
   logic [7:0]      cnt_q [N_CH];
   logic [7:0]      cnt_d [N_CH];
`ifdef DEBOUNCE_LONGPRESS_EN
   logic [15:0]     hold_q [N_CH];
   logic [15:0]     hold_d [N_CH];
`endif
   logic            push;
   evt_t            push_evt;

   evt_t            mem_q [EVT_DEPTH];
   evt_t            mem_d [EVT_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            valid_q, valid_d;
   evt_t            head_q, head_d;
   logic            ovf_q, ovf_d;
   logic            pop, full, wr_en;

   // Prescaler and scan sequencing; a started scan always runs to the last channel.
   always_comb begin
      tick     = en_in && (presc_q == PW'(TICK_DIV - 1));
      presc_d  = (!en_in || tick) ? '0 : presc_q + PW'(1);
      state_d  = state_q;
      ch_idx_d = ch_idx_q;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d  = S_SCAN;
               ch_idx_d = '0;
            end
         end
         S_SCAN: begin
            if (ch_idx_q == CH_W'(N_CH - 1)) begin
               state_d  = S_IDLE;
               ch_idx_d = '0;
            end else begin
               ch_idx_d = ch_idx_q + CH_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_SCAN);
   end

   // Service of the channel selected by ch_idx_q; at most one push per cycle.
   always_comb begin
      clean_d  = clean_q;
      cnt_d    = cnt_q;
      push     = 1'b0;
      push_evt = '0;
`ifdef DEBOUNCE_LONGPRESS_EN
      hold_d   = hold_q;
`endif
      if (state_q == S_SCAN) begin
         if (sync2_q[ch_idx_q] == clean_q[ch_idx_q]) begin
            cnt_d[ch_idx_q] = '0;
         end else if (cnt_q[ch_idx_q] == 8'(STABLE_TICKS - 1)) begin
            clean_d[ch_idx_q] = ~clean_q[ch_idx_q];
            cnt_d[ch_idx_q]   = '0;
            push              = 1'b1;
            push_evt.ch       = ch_idx_q;
            push_evt.rise     = ~clean_q[ch_idx_q];
         end else begin
            cnt_d[ch_idx_q] = cnt_q[ch_idx_q] + 8'd1;
         end
`ifdef DEBOUNCE_LONGPRESS_EN
         // Flip wins the push slot; hold saturates at LONG_TICKS so one long event per press.
         if (push || !clean_q[ch_idx_q]) begin
            hold_d[ch_idx_q] = '0;
         end else if (hold_q[ch_idx_q] != 16'(LONG_TICKS)) begin
            hold_d[ch_idx_q] = hold_q[ch_idx_q] + 16'd1;
            if (hold_q[ch_idx_q] == 16'(LONG_TICKS - 1)) begin
               push              = 1'b1;
               push_evt.ch       = ch_idx_q;
               push_evt.rise     = 1'b1;
               push_evt.long_evt = 1'b1;
            end
         end
`endif
      end
   end

   // Event FIFO; a full FIFO still accepts a push when the head pops in the same cycle.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      pop      = valid_q && evt_ready_in;
      full     = (count_q == CW'(EVT_DEPTH));
      wr_en    = push && (!full || pop);
      if (wr_en) begin
         mem_d[wr_ptr_q] = push_evt;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(wr_en) - CW'(pop);
      if (push && !wr_en) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_in) begin
         ovf_d = 1'b0;
      end
      valid_d = (count_d != '0);
      head_d  = mem_d[rd_ptr_d];
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         presc_q  <= '0;
         state_q  <= S_IDLE;
         ch_idx_q <= '0;
         busy_q   <= 1'b0;
         clean_q  <= '0;
         for (int i = 0; i < int'(N_CH); i++) begin
            cnt_q[i] <= '0;
`ifdef DEBOUNCE_LONGPRESS_EN
            hold_q[i] <= '0;
`endif
         end
         for (int i = 0; i < int'(EVT_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         sync1_q  <= noisy_in;
         sync2_q  <= sync1_q;
         presc_q  <= presc_d;
         state_q  <= state_d;
         ch_idx_q <= ch_idx_d;
         busy_q   <= busy_d;
         clean_q  <= clean_d;
         cnt_q    <= cnt_d;
`ifdef DEBOUNCE_LONGPRESS_EN
         hold_q   <= hold_d;
`endif
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
         ovf_q    <= ovf_d;
      end
   end

   assign clean_out     = clean_q;
   assign busy_out      = busy_q;
   assign evt_valid_out = valid_q;
   assign evt_ch_out    = head_q.ch;
   assign evt_rise_out  = head_q.rise;
   assign evt_long_out  = head_q.long_evt;
   assign ovf_out       = ovf_q;

endmodule
